// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter and its neighbours
// (VC FIFOs, destination FIFOs and the top-level fsm).
package vc_arbiter_pkg;

  localparam int VC_DATA_W   = 6;
  localparam int VC_DEST_BIT = 4;
  localparam int VC_WEIGHT0  = 3;
  localparam int WCNT_W      = 3;

  typedef enum logic {
    GNT_VC0 = 1'b0,
    GNT_VC1 = 1'b1
  } gnt_state_e;

endpackage

// File: rtl/vc_arb_pipe.sv
// Two-stage word pipeline: stage 1 remembers which VC was popped, stage 2
// captures the FIFO read data and decodes the destination push strobe.
module vc_arb_pipe
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W   = VC_DATA_W,
  parameter int DEST_BIT = VC_DEST_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_pop_i,
  input  logic              vc1_pop_i,
  input  logic [DATA_W-1:0] vc0_data_i,
  input  logic [DATA_W-1:0] vc1_data_i,
  output logic              d0_push_o,
  output logic              d1_push_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_next_o
);

  logic              s1_valid_q;
  logic              s1_sel_q;
  logic              d0_push_q;
  logic              d1_push_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_word;

  // FIFO read data is only valid the cycle after the pop, so select it here.
  assign rd_word = s1_sel_q ? vc1_data_i : vc0_data_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 1'b0;
      d0_push_q  <= 1'b0;
      d1_push_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      s1_valid_q <= vc0_pop_i | vc1_pop_i;
      s1_sel_q   <= vc1_pop_i;
      d0_push_q  <= s1_valid_q & ~rd_word[DEST_BIT];
      d1_push_q  <= s1_valid_q &  rd_word[DEST_BIT];
      if (s1_valid_q) begin
        data_q <= rd_word;
      end
    end
  end

  // Occupancy the pipeline will have after this edge; lets the idle flag be registered without lag.
  assign busy_next_o = vc0_pop_i | vc1_pop_i | s1_valid_q;

  assign d0_push_o = d0_push_q;
  assign d1_push_o = d1_push_q;
  assign data_o    = data_q;

endmodule

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler moving words from VC0/VC1 into D0/D1;
// routing is by one destination bit carried in each word.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W   = VC_DATA_W,
  parameter int DEST_BIT = VC_DEST_BIT,
  parameter int WEIGHT0  = VC_WEIGHT0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] data_out,
  output logic              arb_idle
);

  localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(WEIGHT0 - 1);

  gnt_state_e        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              arb_idle_q;
  logic              can_pop;
  logic              pop0, pop1;
  logic              busy_next;

  // Destination is unknown before the read, so either almost_full blocks pops.
  // Reset is folded in so pop strobes fall asynchronously with it.
  assign can_pop = enable & ~d0_almost_full & ~d1_almost_full & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GNT_VC0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    if (can_pop) begin
      case (state_q)
        GNT_VC0: begin
          if (!vc0_empty) begin
            pop0 = 1'b1;
            if (!vc1_empty) begin
              if (cnt_q == CNT_LAST) begin
                state_d = GNT_VC1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + WCNT_W'(1);
              end
            end
          end else if (!vc1_empty) begin
            // Work-conserving: VC1 borrows the slot without spending its turn.
            pop1 = 1'b1;
          end
        end
        GNT_VC1: begin
          pop1    = ~vc1_empty;
          state_d = GNT_VC0;
        end
        default: state_d = GNT_VC0;
      endcase
    end
  end

  vc_arb_pipe #(
    .DATA_W   (DATA_W),
    .DEST_BIT (DEST_BIT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .vc0_pop_i   (pop0),
    .vc1_pop_i   (pop1),
    .vc0_data_i  (vc0_data),
    .vc1_data_i  (vc1_data),
    .d0_push_o   (d0_push),
    .d1_push_o   (d1_push),
    .data_o      (data_out),
    .busy_next_o (busy_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_idle_q <= 1'b1;
    end else begin
      arb_idle_q <= vc0_empty & vc1_empty & ~busy_next;
    end
  end

  assign vc0_pop  = pop0;
  assign vc1_pop  = pop1;
  assign arb_idle = arb_idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed self-checking bench for vc_arbiter; behavioural VC FIFOs feed the DUT,
// and each scenario task compares outputs cycle by cycle against hand-worked values.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       vc0_empty = 1'b1;
  logic       vc1_empty = 1'b1;
  logic [5:0] vc0_data = 6'h00;
  logic [5:0] vc1_data = 6'h00;
  logic       d0_almost_full = 1'b0;
  logic       d1_almost_full = 1'b0;
  logic       vc0_pop, vc1_pop, d0_push, d1_push, arb_idle;
  logic [5:0] data_out;

  logic [5:0] q0[$];
  logic [5:0] q1[$];

  int checks = 0;
  int fails  = 0;

  vc_arbiter #(
    .DATA_W   (6),
    .DEST_BIT (4),
    .WEIGHT0  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .arb_idle       (arb_idle)
  );

  always #5 clk = ~clk;

  // VC FIFO models: read data and empty both reflect a pop on the following cycle.
  always @(posedge clk) begin
    if (vc0_pop && q0.size() > 0) begin
      vc0_data <= q0[0];
      q0.delete(0);
    end
    if (vc1_pop && q1.size() > 0) begin
      vc1_data <= q1[0];
      q1.delete(0);
    end
    vc0_empty <= (q0.size() == 0);
    vc1_empty <= (q1.size() == 0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    reset = 1'b1;
    enable = 1'b0;
    d0_almost_full = 1'b0;
    d1_almost_full = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) toPos();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    q0.push_back(6'h07);
    q0.push_back(6'h08);
    q1.push_back(6'h31);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 6;
      if (vc0_pop !== 1'b0) begin fails++; $display("[TB] FAIL reset_vc0_pop cyc%0d got %b exp 0", i, vc0_pop); end
      if (vc1_pop !== 1'b0) begin fails++; $display("[TB] FAIL reset_vc1_pop cyc%0d got %b exp 0", i, vc1_pop); end
      if (d0_push !== 1'b0) begin fails++; $display("[TB] FAIL reset_d0_push cyc%0d got %b exp 0", i, d0_push); end
      if (d1_push !== 1'b0) begin fails++; $display("[TB] FAIL reset_d1_push cyc%0d got %b exp 0", i, d1_push); end
      if (data_out !== 6'h00) begin fails++; $display("[TB] FAIL reset_data cyc%0d got %h exp 00", i, data_out); end
      if (arb_idle !== 1'b1) begin fails++; $display("[TB] FAIL reset_idle cyc%0d got %b exp 1", i, arb_idle); end
      toPos();
    end
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (vc0_pop !== 1'b1) begin fails++; $display("[TB] FAIL release_vc0_pop got %b exp 1", vc0_pop); end
    if (vc1_pop !== 1'b0) begin fails++; $display("[TB] FAIL release_vc1_pop got %b exp 0", vc1_pop); end
  endtask

  task automatic test_vc0_stream();
    logic [5:0] w[4];
    w = '{6'h01, 6'h02, 6'h0B, 6'h0F};
    applyStimulus();
    for (int k = 0; k < 4; k++) q0.push_back(w[k]);
    toPos();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks += 4;
      if (vc0_pop !== (i < 4)) begin fails++; $display("[TB] FAIL stream_vc0_pop cyc%0d got %b exp %b", i, vc0_pop, (i < 4)); end
      if (vc1_pop !== 1'b0) begin fails++; $display("[TB] FAIL stream_vc1_pop cyc%0d got %b exp 0", i, vc1_pop); end
      if (d0_push !== (i >= 2 && i < 6)) begin fails++; $display("[TB] FAIL stream_d0_push cyc%0d got %b exp %b", i, d0_push, (i >= 2 && i < 6)); end
      if (d1_push !== 1'b0) begin fails++; $display("[TB] FAIL stream_d1_push cyc%0d got %b exp 0", i, d1_push); end
      if (i >= 2 && i < 6) begin
        checks++;
        if (data_out !== w[i-2]) begin fails++; $display("[TB] FAIL stream_data cyc%0d got %h exp %h", i, data_out, w[i-2]); end
      end
      if (i == 7) begin
        checks++;
        if (arb_idle !== 1'b1) begin fails++; $display("[TB] FAIL stream_idle got %b exp 1", arb_idle); end
      end
      toPos();
    end
  endtask

  task automatic test_weighted();
    logic       exp_v1[8];
    logic [5:0] exp_d[8];
    int         n0, n1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      exp_v1[k] = ((k % 4) == 3);
      if (exp_v1[k]) begin exp_d[k] = 6'(48 + n1); n1++; end
      else begin exp_d[k] = 6'(n0); n0++; end
    end
    applyStimulus();
    for (int k = 0; k < 8; k++) q0.push_back(6'(k));
    for (int k = 0; k < 4; k++) q1.push_back(6'(48 + k));
    toPos();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 4;
      if (i < 8) begin
        if (vc0_pop !== !exp_v1[i]) begin fails++; $display("[TB] FAIL wrr_vc0_pop cyc%0d got %b exp %b", i, vc0_pop, !exp_v1[i]); end
        if (vc1_pop !== exp_v1[i]) begin fails++; $display("[TB] FAIL wrr_vc1_pop cyc%0d got %b exp %b", i, vc1_pop, exp_v1[i]); end
      end else begin
        if (vc0_pop !== 1'b0) begin fails++; $display("[TB] FAIL wrr_vc0_pop cyc%0d got %b exp 0", i, vc0_pop); end
        if (vc1_pop !== 1'b0) begin fails++; $display("[TB] FAIL wrr_vc1_pop cyc%0d got %b exp 0", i, vc1_pop); end
      end
      if (i >= 2) begin
        checks++;
        if (d0_push !== !exp_v1[i-2]) begin fails++; $display("[TB] FAIL wrr_d0_push cyc%0d got %b exp %b", i, d0_push, !exp_v1[i-2]); end
        if (d1_push !== exp_v1[i-2]) begin fails++; $display("[TB] FAIL wrr_d1_push cyc%0d got %b exp %b", i, d1_push, exp_v1[i-2]); end
        if (data_out !== exp_d[i-2]) begin fails++; $display("[TB] FAIL wrr_data cyc%0d got %h exp %h", i, data_out, exp_d[i-2]); end
      end else begin
        if (d0_push !== 1'b0) begin fails++; $display("[TB] FAIL wrr_d0_push cyc%0d got %b exp 0", i, d0_push); end
        if (d1_push !== 1'b0) begin fails++; $display("[TB] FAIL wrr_d1_push cyc%0d got %b exp 0", i, d1_push); end
      end
      toPos();
      if (i == 7) enable = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] pop_mask;
    logic [10:0] push_mask;
    int          k;
    pop_mask  = 11'b00011110011;
    push_mask = 11'b01111001100;
    k = 0;
    applyStimulus();
    for (int j = 0; j < 6; j++) q0.push_back(6'(j + 1));
    toPos();
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks += 4;
      if (vc0_pop !== pop_mask[i]) begin fails++; $display("[TB] FAIL bp_vc0_pop cyc%0d got %b exp %b", i, vc0_pop, pop_mask[i]); end
      if (vc1_pop !== 1'b0) begin fails++; $display("[TB] FAIL bp_vc1_pop cyc%0d got %b exp 0", i, vc1_pop); end
      if (d0_push !== push_mask[i]) begin fails++; $display("[TB] FAIL bp_d0_push cyc%0d got %b exp %b", i, d0_push, push_mask[i]); end
      if (d1_push !== 1'b0) begin fails++; $display("[TB] FAIL bp_d1_push cyc%0d got %b exp 0", i, d1_push); end
      if (push_mask[i]) begin
        k++;
        checks++;
        if (data_out !== 6'(k)) begin fails++; $display("[TB] FAIL bp_data cyc%0d got %h exp %h", i, data_out, 6'(k)); end
      end
      toPos();
      if (i == 1) d1_almost_full = 1'b1;
      if (i == 3) d1_almost_full = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    logic [5:0] w[4];
    w = '{6'h0A, 6'h0C, 6'h0D, 6'h0E};
    applyStimulus();
    for (int j = 0; j < 4; j++) q0.push_back(w[j]);
    toPos();
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks += 3;
      if (vc0_pop !== (i < 2)) begin fails++; $display("[TB] FAIL en_vc0_pop cyc%0d got %b exp %b", i, vc0_pop, (i < 2)); end
      if (d0_push !== (i == 2 || i == 3)) begin fails++; $display("[TB] FAIL en_d0_push cyc%0d got %b exp %b", i, d0_push, (i == 2 || i == 3)); end
      if (d1_push !== 1'b0) begin fails++; $display("[TB] FAIL en_d1_push cyc%0d got %b exp 0", i, d1_push); end
      if (i == 2 || i == 3) begin
        checks++;
        if (data_out !== w[i-2]) begin fails++; $display("[TB] FAIL en_data cyc%0d got %h exp %h", i, data_out, w[i-2]); end
      end
      if (i >= 1) begin
        checks++;
        if (arb_idle !== (i == 8)) begin fails++; $display("[TB] FAIL en_idle cyc%0d got %b exp %b", i, arb_idle, (i == 8)); end
      end
      toPos();
      if (i == 1) enable = 1'b0;
      if (i == 5) q0.delete();
    end
  endtask

  task automatic test_single_word();
    applyStimulus();
    q0.push_back(6'h05);
    q1.push_back(6'h11);
    q1.push_back(6'h3A);
    toPos();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 4;
      if (vc0_pop !== (i == 0)) begin fails++; $display("[TB] FAIL one_vc0_pop cyc%0d got %b exp %b", i, vc0_pop, (i == 0)); end
      if (vc1_pop !== (i == 1 || i == 2)) begin fails++; $display("[TB] FAIL one_vc1_pop cyc%0d got %b exp %b", i, vc1_pop, (i == 1 || i == 2)); end
      if (d0_push !== (i == 2)) begin fails++; $display("[TB] FAIL one_d0_push cyc%0d got %b exp %b", i, d0_push, (i == 2)); end
      if (d1_push !== (i == 3 || i == 4)) begin fails++; $display("[TB] FAIL one_d1_push cyc%0d got %b exp %b", i, d1_push, (i == 3 || i == 4)); end
      if (i == 2) begin
        checks++;
        if (data_out !== 6'h05) begin fails++; $display("[TB] FAIL one_data0 got %h exp 05", data_out); end
      end
      if (i == 3) begin
        checks++;
        if (data_out !== 6'h11) begin fails++; $display("[TB] FAIL one_data1 got %h exp 11", data_out); end
      end
      if (i >= 4) begin
        checks++;
        if (data_out !== 6'h3A) begin fails++; $display("[TB] FAIL one_data_hold cyc%0d got %h exp 3a", i, data_out); end
      end
      toPos();
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus();
    q0.push_back(6'h02);
    q0.push_back(6'h03);
    q0.push_back(6'h04);
    toPos();
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks += 2;
    if (d0_push !== 1'b1) begin fails++; $display("[TB] FAIL mid_push_before got %b exp 1", d0_push); end
    if (vc0_pop !== 1'b1) begin fails++; $display("[TB] FAIL mid_pop_before got %b exp 1", vc0_pop); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (d0_push !== 1'b0) begin fails++; $display("[TB] FAIL mid_push_async got %b exp 0", d0_push); end
    if (vc0_pop !== 1'b0) begin fails++; $display("[TB] FAIL mid_pop_async got %b exp 0", vc0_pop); end
    if (data_out !== 6'h00) begin fails++; $display("[TB] FAIL mid_data_async got %h exp 00", data_out); end
    if (arb_idle !== 1'b1) begin fails++; $display("[TB] FAIL mid_idle_async got %b exp 1", arb_idle); end
    enable = 1'b0;
    toPos();
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] starting vc_arbiter directed tests");
    test_reset();
    test_vc0_stream();
    test_weighted();
    test_backpressure();
    test_enable_drop();
    test_single_word();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
